// File: rtl/arb_rr_4_to_1.sv
// -----------------------------------------------------------------------------
// mux_4_to_1 : WIDTH-bit 4:1 data selector (combinational).
//   sel      : 2-bit select
//   d0..d3   : WIDTH-bit data inputs
//   y        : selected data
//
// arb_rr_4_to_1 : round-robin arbiter merging four valid/ready channels into
// one registered output stream carrying the data and its 2-bit source index.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid[3:0]     : per-channel request
//   in_data0..3       : per-channel data
//   in_ready[3:0]     : one-hot "your item is taken this cycle"
//   out_valid         : output register holds an item
//   out_data, out_sel : item data and the channel that supplied it
//   out_ready         : downstream accepts the output item this cycle
// -----------------------------------------------------------------------------

module mux_4_to_1 #(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    unique case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

module arb_rr_4_to_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  logic [1:0]       ptr;
  logic [3:0]       grant;
  logic [1:0]       gsel;
  logic             any_req;
  logic             can_load;
  logic [WIDTH-1:0] sel_data;

  assign any_req  = |in_valid;
  // A full register may be refilled on the same edge it drains.
  assign can_load = !out_valid || out_ready;

  // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); first requester wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    grant = '0;
    gsel  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        gsel       = idx;
        found      = 1'b1;
      end
    end
  end

  // Nothing is reported as taken while reset is discarding the transfer.
  assign in_ready = (can_load && !rst) ? grant : 4'b0000;

  mux_4_to_1 #(.WIDTH(WIDTH)) u_mux (
    .sel (gsel),
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .y   (sel_data)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd0;
    end else if (can_load) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= gsel;
        ptr       <= gsel + 2'd1;  // 3 wraps to 0
      end else begin
        out_valid <= 1'b0;
      end
    end
    // Stall (out_valid && !out_ready): everything holds.
  end

endmodule

// File: tb/tb_arb_rr_4_to_1.sv
// -----------------------------------------------------------------------------
// Directed testbench for arb_rr_4_to_1: reset, rotation, sparse wrap,
// backpressure, idle drain and mid-operation reset, all with hand-computed
// expectations.
// -----------------------------------------------------------------------------

module tb_arb_rr_4_to_1;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  arb_rr_4_to_1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] s,
                           input logic [WIDTH-1:0] d);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".sel"},   32'(out_sel),   32'(s));
    check({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  logic [WIDTH-1:0] rot_data [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};

  initial begin
    // 1. Reset held 2 cycles with all channels valid.
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_data0  = 4'hA;
    in_data1  = 4'hB;
    in_data2  = 4'hC;
    in_data3  = 4'hD;
    out_ready = 1'b1;
    step();
    step();
    check_out("reset", 1'b0, 2'd0, 4'h0);
    rst = 1'b0;
    #1;
    check("reset.first_grant", 32'(in_ready), 32'(4'b0001));

    // 2. Full rotation 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rot%0d.in_ready", i), 32'(in_ready), 32'(4'b0001 << (i % 4)));
      step();
      check_out($sformatf("rot%0d", i), 1'b1, 2'(i % 4), rot_data[i]);
    end

    // 3. Sparse: last grant = 1, then 1001 -> channel 3, then wrap to 0.
    in_valid = 4'b0010;
    #1;
    check("sparse.pre_ready", 32'(in_ready), 32'(4'b0010));
    step();
    check_out("sparse.pre", 1'b1, 2'd1, 4'hB);
    in_valid = 4'b1001;
    #1;
    check("sparse.g3_ready", 32'(in_ready), 32'(4'b1000));
    step();
    check_out("sparse.g3", 1'b1, 2'd3, 4'hD);
    check("sparse.g0_ready", 32'(in_ready), 32'(4'b0001));
    step();
    check_out("sparse.g0", 1'b1, 2'd0, 4'hA);

    // 4. Backpressure: load channel 2 with 5, stall 3 cycles, release.
    in_data2 = 4'h5;
    in_valid = 4'b0100;
    #1;
    check("bp.load_ready", 32'(in_ready), 32'(4'b0100));
    step();
    check_out("bp.load", 1'b1, 2'd2, 4'h5);
    out_ready = 1'b0;
    in_valid  = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp.stall%0d.in_ready", i), 32'(in_ready), 32'(4'b0000));
      step();
      check_out($sformatf("bp.stall%0d", i), 1'b1, 2'd2, 4'h5);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'(4'b1000));
    step();
    check_out("bp.release", 1'b1, 2'd3, 4'hD);

    // 5. Idle drain: out_valid falls, data/sel/ptr hold (ptr = 0).
    in_valid = 4'b0000;
    #1;
    check("idle.in_ready", 32'(in_ready), 32'(4'b0000));
    step();
    check_out("idle", 1'b0, 2'd3, 4'hD);
    in_valid = 4'b1111;
    #1;
    check("idle.ptr_held", 32'(in_ready), 32'(4'b0001));
    step();
    check_out("idle.next", 1'b1, 2'd0, 4'hA);

    // 6. Mid-operation reset while stalled with ptr = 1.
    out_ready = 1'b0;
    #1;
    check("midrst.stall_ready", 32'(in_ready), 32'(4'b0000));
    rst = 1'b1;
    step();
    check_out("midrst", 1'b0, 2'd0, 4'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst.ptr_cleared", 32'(in_ready), 32'(4'b0001));
    step();
    check_out("midrst.next", 1'b1, 2'd0, 4'hA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
